cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
- Splits a WIDTH-bit operation into GROUP-bit CLA slices, one slice per pipeline stage.
- Valid/ready handshake on both sides; one operation accepted per cycle when not stalled.
- Provides carry-out and signed overflow; used as the shared arithmetic unit in datapath labs.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per CLA slice and per pipeline stage; slice uses internal generate/propagate lookahead.
- NSTG, WIDTH/GROUP (derived localparam, not overridable), pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A, unsigned or two's complement.
- in_b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in add mode only.
- sub  in  1  0 = A+B+cin; 1 = A-B (cin ignored).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in sub mode, 1 = no borrow (A >= B unsigned).
- ovf  out  1  signed overflow.

Behaviour:
- Reset (async, rst=1): all stage valid bits=0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 while rst=1 and after release. In-flight beats are discarded, not emitted.
- Operand prep at accept: b_eff = sub ? ~in_b : in_b; c0 = sub ? 1 : cin.
- Beat accepted when in_valid && in_ready at a rising edge.
- Stage k (0..NSTG-1) latches slice k: sum bits [k*GROUP +: GROUP] = a_k + b_eff_k + carry_k, using GROUP-bit CLA logic. Carry out goes to stage k+1.
- Unprocessed upper operand bits and finished lower sum bits travel with the beat (skew registers).
- Latency: a beat accepted at edge t gives out_valid=1 after edge t+NSTG-1. With defaults, result is visible 4 cycles after acceptance; no combinational path from in_* to out_*.
- Final stage registers sum, cout = carry out of bit WIDTH-1, ovf = carry into MSB XOR carry out of MSB.
- Throughput: 1 beat/cycle with out_ready held high. Results emerge in acceptance order.
- Stall: stall = out_valid && !out_ready.
  - During stall every stage holds.
  - in_ready = !stall (combinational from out_ready).
  - sum/cout/ovf held stable while out_valid=1 and out_ready=0.
- Bubbles: in_valid=0 inserts an invalid slot; that slot's data is don't-care and never raises out_valid. Bubbles are not collapsed while not stalled.
- Simultaneous accept and output with out_ready=1: both occur the same edge; no loss, no duplication.
- Output register: when no new valid beat reaches the last stage and out_valid && out_ready, out_valid clears. sum/cout/ovf keep last values.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - Wrap-around is reported only via cout/ovf.
  - A sub with A=B gives sum=0, cout=1, ovf=0.
- Synthesis parameter check: WIDTH % GROUP != 0 is an elaboration error ($error in generate).

Test Plan:
- Reset/latency (defaults): after rst pulse, send a=16'h1234, b=16'h4321, cin=1, sub=0 with out_ready=1 -> out_valid exactly 4 cycles later; sum=16'h5556, cout=0, ovf=0.
- Carry ripple across all slices: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'd5, b=16'd7, sub=1, cin=1 -> sum=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Backpressure: stream 8 beats back to back, drop out_ready for 3 cycles mid-stream -> in_ready low exactly those cycles; held output stable; all 8 results correct and in order; none lost or duplicated.
- Reset mid-operation: accept 3 beats, assert rst one cycle before the first result -> out_valid=0 and outputs 0 immediately; none of the 3 results ever appear. A new beat after release returns with normal latency.
- Random + parameter sweep: 1000 random beats with random in_valid/out_ready, checked against a golden A+B+cin / A-B model -> zero mismatches. Repeat at WIDTH=32, GROUP=8 (latency 4) and WIDTH=8, GROUP=8 (latency 1).

Source files
------------

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
// into GROUP-bit slices. Each slice is resolved with full generate/propagate
// lookahead, and one slice is resolved per pipeline stage. Latency is
// NSTG = WIDTH/GROUP cycles. Throughput is one beat per cycle unless the
// output is stalled.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset (control and outputs)
//   in_valid   in   operand beat present
//   in_ready   out  beat can be accepted this cycle (= !stall)
//   in_a       in   operand A [WIDTH]
//   in_b       in   operand B [WIDTH]
//   cin        in   carry-in, add mode only
//   sub        in   0: A+B+cin, 1: A-B (cin ignored)
//   out_valid  out  result present
//   out_ready  in   downstream accepts result
//   sum        out  result modulo 2^WIDTH
//   cout       out  carry out of the MSB (sub: 1 = no borrow)
//   ovf        out  signed overflow
// ---------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / GROUP;
    // Inter-stage register count. A single-stage build needs none, but the
    // array is kept at one entry so that it stays legal.
    localparam int NREG = (NSTG > 1) ? NSTG - 1 : 1;

    generate
        if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_param_check
            $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
        end
    endgenerate

    // One GROUP-bit lookahead slice.
    // Result layout: {carry into slice MSB, carry out, sum[GROUP-1:0]}.
    // Every internal carry is expanded as the full sum of products
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
    // so no carry ripples inside the slice.
    function automatic logic [GROUP+1:0] cla_slice(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             c0
    );
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        logic             prod;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            prod = c0;
            for (int j = 0; j <= i; j++) begin
                prod = prod & p[j];
            end
            term = prod;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                term = term | prod;
            end
            c[i+1] = term;
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    // Skew registers between stages. Stage k's register holds:
    //   the full operands, of which only the slices above k are still needed;
    //   the partial sum, whose slices 0..k are finished;
    //   the carry out of slice k.
    logic [WIDTH-1:0] a_p     [NREG];
    logic [WIDTH-1:0] b_p     [NREG];
    logic [WIDTH-1:0] sum_p   [NREG];
    logic             carry_p [NREG];

    // Valid bit per stage. The last entry is the output-register valid.
    logic             vld_p   [NSTG];

    // Stage inputs (from ports for stage 0, else from the previous register)
    logic [WIDTH-1:0] a_in    [NSTG];
    logic [WIDTH-1:0] b_in    [NSTG];
    logic [WIDTH-1:0] sum_in  [NSTG];
    logic             c_in    [NSTG];
    logic             vld_in  [NSTG];

    // Stage results
    logic [GROUP+1:0] slice_r [NSTG];
    logic [WIDTH-1:0] sum_nxt [NSTG];

    logic stall;

    assign out_valid = vld_p[NSTG-1];
    // Everything moves in lock-step, so a held output freezes the whole pipe.
    assign stall     = vld_p[NSTG-1] & ~out_ready;
    assign in_ready  = ~stall;

    always_comb begin
        // Operand prep at accept: subtraction is A + ~B + 1.
        a_in[0]   = in_a;
        b_in[0]   = sub ? ~in_b : in_b;
        c_in[0]   = sub ? 1'b1 : cin;
        sum_in[0] = '0;
        vld_in[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            a_in[k]   = a_p[k-1];
            b_in[k]   = b_p[k-1];
            c_in[k]   = carry_p[k-1];
            sum_in[k] = sum_p[k-1];
            vld_in[k] = vld_p[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            slice_r[k] = cla_slice(a_in[k][k*GROUP +: GROUP],
                                   b_in[k][k*GROUP +: GROUP],
                                   c_in[k]);
            sum_nxt[k] = sum_in[k];
            sum_nxt[k][k*GROUP +: GROUP] = slice_r[k][GROUP-1:0];
        end
    end

    // Control and output registers. These carry reset, so in-flight beats
    // are discarded and the visible result clears immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= 1'b0;
            end
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= vld_in[k];
            end
            // Bubbles leave the last result in place.
            if (vld_in[NSTG-1]) begin
                sum  <= sum_nxt[NSTG-1];
                cout <= slice_r[NSTG-1][GROUP];
                ovf  <= slice_r[NSTG-1][GROUP+1] ^ slice_r[NSTG-1][GROUP];
            end
        end
    end

    // Datapath skew registers. These have no reset. Their contents only
    // matter when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int k = 0; k < NSTG - 1; k++) begin
                a_p[k]     <= a_in[k];
                b_p[k]     <= b_in[k];
                sum_p[k]   <= sum_nxt[k];
                carry_p[k] <= slice_r[k][GROUP];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Single-slice build: latency 1
    cla_pipe_adder #(.WIDTH(8), .GROUP(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } slot_t;

    slot_t pm [3];   // beats in flight ahead of the output register
    slot_t om;       // expected output register

    function automatic slot_t gold(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input logic s, input logic v);
        logic [15:0] be;
        logic        c0;
        logic [16:0] t;
        slot_t       r;
        be   = s ? ~b : b;
        c0   = s ? 1'b1 : c;
        t    = {1'b0, a} + {1'b0, be} + {16'b0, c0};
        r.v  = v;
        r.s  = t[15:0];
        r.co = t[16];
        r.ov = (a[15] == be[15]) && (t[15] != a[15]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        om = '0;
        for (int k = 0; k < 3; k++) pm[k] = '0;
    endtask

    // Inputs are already driven. Check in_ready, clock once, update the model,
    // then check all outputs of the 16-bit instance.
    task automatic cycle();
        logic  stall;
        slot_t nin;
        slot_t nl;
        #1;
        stall = om.v && !out_ready;
        chk("in_ready", in_ready, !stall);
        nin = gold(in_a, in_b, cin, sub, in_valid);
        @(posedge clk);
        if (!stall) begin
            nl    = pm[2];
            pm[2] = pm[1];
            pm[1] = pm[0];
            pm[0] = nin;
            om.v  = nl.v;
            if (nl.v) begin
                om.s  = nl.s;
                om.co = nl.co;
                om.ov = nl.ov;
            end
        end
        #1;
        chk("out_valid", out_valid, om.v);
        chk("sum", sum, om.s);
        chk("cout", cout, om.co);
        chk("ovf", ovf, om.ov);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        cin      = c;
        sub      = s;
    endtask

    logic [15:0] ca_a [5] = '{16'hFFFF, 16'h7FFF, 16'd5,    16'h8000, 16'hA5A5};
    logic [15:0] ca_b [5] = '{16'h0000, 16'h0001, 16'd7,    16'h0001, 16'hA5A5};
    logic        ca_c [5] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
    logic        ca_s [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1};
    logic [15:0] ex_s [5] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    logic        ex_c [5] = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1};
    logic        ex_o [5] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cnt;
        int ir_low;
        int acc;
        int ghost;
        logic stall_now;

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Reset / latency
        out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
        cycle();
        chk("lat8_valid", out_valid8, 1);
        chk("lat8_sum", sum8, 8'h56);
        chk("lat8_cout", cout8, 0);
        chk("lat8_ovf", ovf8, 0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle();
        chk("lat8_bubble", out_valid8, 0);
        cycle();
        chk("lat_not_early", out_valid, 0);
        cycle();
        chk("lat_valid", out_valid, 1);
        chk("lat_sum", sum, 16'h5556);
        chk("lat_cout", cout, 0);
        chk("lat_ovf", ovf, 0);
        cycle();
        chk("lat_clear", out_valid, 0);
        chk("lat_sum_kept", sum, 16'h5556);

        // Carry ripple, overflow, subtract, A==B subtract
        for (int c = 0; c < 9; c++) begin
            if (c < 5) drive(1'b1, ca_a[c], ca_b[c], ca_c[c], ca_s[c]);
            else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            cycle();
            if (c == 0) begin
                chk("c8_sum", sum8, 8'h00);
                chk("c8_cout", cout8, 1);
            end
            if (c == 2) begin
                chk("s8_sum", sum8, 8'hFE);
                chk("s8_cout", cout8, 0);
            end
            if (c >= 3 && c < 8) begin
                chk("dir_valid", out_valid, 1);
                chk("dir_sum", sum, ex_s[c-3]);
                chk("dir_cout", cout, ex_c[c-3]);
                chk("dir_ovf", ovf, ex_o[c-3]);
            end
        end

        // Backpressure: 8 beats, out_ready low for cycles 5..7
        idx    = 0;
        cnt    = 0;
        ir_low = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (idx < 8) drive(1'b1, 16'(idx * 16'h1111), 16'h0101, idx[0], 1'b0);
            else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            stall_now = om.v && !out_ready;
            #1;
            if (!in_ready) ir_low++;
            if (out_valid && out_ready) cnt++;
            cycle();
            if (in_valid && !stall_now) idx++;
        end
        out_ready = 1'b1;
        chk("bp_accepted", idx, 8);
        chk("bp_in_ready_low", ir_low, 3);
        chk("bp_delivered", cnt, 8);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'h0100 + 16'(k), 16'h0022, 1'b0, 1'b0);
            cycle();
        end
        do_reset();
        ghost = 0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (out_valid) ghost++;
        end
        chk("rst_no_ghost", ghost, 0);
        drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("post_rst_not_early", out_valid, 0);
        cycle();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", sum, 16'h1000);

        // Random traffic
        acc = 0;
        for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            stall_now = om.v && !out_ready;
            cycle();
            if (in_valid && !stall_now) acc++;
        end
        chk("rand_accepted", acc, 1000);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("rand_drained", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
